// File: rtl/eth_tx_framer.sv
// Byte-wide Ethernet TX framer: preamble, SFD, payload, FCS, IFG.
// Define ETH_TX_PAD_EN to zero-pad short payloads to MIN_PAYLOAD bytes.

module crc32 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [31:0]           crc_o
);
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  // MSB-first register; data bits enter LSB first, as on the wire
  always_comb begin
    crc_d = crc_q;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (crc_d[31] ^ data_i[i]) begin
        crc_d = {crc_d[30:0], 1'b0} ^ POLY;
      end else begin
        crc_d = {crc_d[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      crc_q <= '1;
    end else if (en_i) begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;
endmodule

module eth_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IFG_LEN      = 12,
`ifdef ETH_TX_PAD_EN
  parameter int MIN_PAYLOAD  = 60,
`endif
  parameter int MAX_PAYLOAD  = 1514
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] s_data_i,
  input  logic       s_valid_i,
  input  logic       s_last_i,
  output logic       s_ready_o,
  output logic [7:0] tx_data_o,
  output logic       tx_en_o,
  output logic       tx_er_o,
  output logic       busy_o,
  output logic       abort_o
);
  typedef enum logic [3:0] {
    IDLE, PREAMBLE, SFD, DATA, PAD,
    FCS, IFG, ABORT, DRAIN
  } state_e;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 1);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_PAYLOAD);
`ifdef ETH_TX_PAD_EN
  localparam logic [10:0] MIN_LEN  = 11'(MIN_PAYLOAD);
`endif

  state_e      state_q;
  logic [10:0] cnt_q;
  logic [10:0] cnt_inc;
  logic [7:0]  aux_q;
  logic        last_q;
  logic [7:0]  tx_data_q;
  logic        tx_en_q;
  logic        tx_er_q;
  logic        abort_q;

  logic        crc_clr;
  logic        crc_en;
  logic [7:0]  crc_din;
  logic [31:0] crc;
  logic        accept;
  logic        oversize;
  logic [7:0]  fcs_byte;

  function automatic logic [7:0] bitrev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  assign s_ready_o = (state_q == DATA) || (state_q == DRAIN);
  assign oversize  = (cnt_q == MAX_LEN);
  assign accept    = (state_q == DATA) && s_valid_i && !oversize;
  assign cnt_inc   = cnt_q + 11'd1;
  assign crc_clr   = state_q inside {IDLE, PREAMBLE, SFD};
  assign crc_en    = accept || (state_q == PAD);
  assign crc_din   = (state_q == PAD) ? 8'h00 : s_data_i;

  crc32 #(
    .DATA_WIDTH(8)
  ) u_crc (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear_i(crc_clr),
    .en_i   (crc_en),
    .data_i (crc_din),
    .crc_o  (crc)
  );

  always_comb begin
    unique case (aux_q[1:0])
      2'd0: fcs_byte = ~bitrev8(crc[31:24]);
      2'd1: fcs_byte = ~bitrev8(crc[23:16]);
      2'd2: fcs_byte = ~bitrev8(crc[15:8]);
      default: fcs_byte = ~bitrev8(crc[7:0]);
    endcase
  end

  // Outputs run one cycle behind state: each state registers the next line byte
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      aux_q     <= '0;
      last_q    <= 1'b0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      tx_er_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      tx_er_q <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          cnt_q     <= '0;
          aux_q     <= 8'd1;
          last_q    <= 1'b0;
          if (s_valid_i) begin
            tx_en_q   <= 1'b1;
            tx_data_q <= 8'h55;
            state_q   <= (PREAMBLE_LEN > 1) ? PREAMBLE : SFD;
          end
        end
        PREAMBLE: begin
          tx_data_q <= 8'h55;
          aux_q     <= aux_q + 8'd1;
          if (aux_q == PRE_LAST) state_q <= SFD;
        end
        SFD: begin
          tx_data_q <= 8'hD5;
          state_q   <= DATA;
        end
        DATA: begin
          if (accept) begin
            tx_data_q <= s_data_i;
            cnt_q     <= cnt_inc;
            if (s_last_i) begin
              aux_q <= '0;
`ifdef ETH_TX_PAD_EN
              state_q <= (cnt_inc < MIN_LEN) ? PAD : FCS;
`else
              state_q <= FCS;
`endif
            end
          end else begin
            tx_en_q   <= 1'b1;
            tx_data_q <= 8'h00;
            tx_er_q   <= 1'b1;
            abort_q   <= 1'b1;
            last_q    <= s_valid_i && s_last_i;
            state_q   <= ABORT;
          end
        end
`ifdef ETH_TX_PAD_EN
        PAD: begin
          tx_data_q <= 8'h00;
          cnt_q     <= cnt_inc;
          if (cnt_inc == MIN_LEN) begin
            aux_q   <= '0;
            state_q <= FCS;
          end
        end
`endif
        FCS: begin
          tx_data_q <= fcs_byte;
          aux_q     <= aux_q + 8'd1;
          if (aux_q[1:0] == 2'd3) begin
            aux_q   <= '0;
            state_q <= IFG;
          end
        end
        IFG: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          aux_q     <= aux_q + 8'd1;
          if (aux_q == IFG_LAST) state_q <= IDLE;
        end
        ABORT: begin
          tx_en_q   <= 1'b0;
          tx_data_q <= 8'h00;
          aux_q     <= '0;
          state_q   <= last_q ? IFG : DRAIN;
        end
        DRAIN: begin
          if (s_valid_i && s_last_i) state_q <= IFG;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data_o = tx_data_q;
  assign tx_en_o   = tx_en_q;
  assign tx_er_o   = tx_er_q;
  assign abort_o   = abort_q;
  assign busy_o    = (state_q != IDLE);
endmodule

// File: tb/tb_eth_tx_framer.sv
// Self-checking bench for eth_tx_framer (pad on or off by ETH_TX_PAD_EN).
// Line bytes are captured per cycle and compared to a reference frame.

module tb_eth_tx_framer;
`ifdef ETH_TX_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;
  logic [7:0] tx_data_o;
  logic       tx_en_o;
  logic       tx_er_o;
  logic       busy_o;
  logic       abort_o;

  eth_tx_framer dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .s_data_i (s_data_i),
    .s_valid_i(s_valid_i),
    .s_last_i (s_last_i),
    .s_ready_o(s_ready_o),
    .tx_data_o(tx_data_o),
    .tx_en_o  (tx_en_o),
    .tx_er_o  (tx_er_o),
    .busy_o   (busy_o),
    .abort_o  (abort_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       er;
    logic       ab;
    logic [7:0] d;
  } sample_t;

  typedef struct {
    int          len;
    int          mode;
    int          exp_en;
    bit          known;
    logic [31:0] fcs;
  } vec_t;

  sample_t     mon_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] exp_fcs;
  int          tests = 0;
  int          fails = 0;
  bit          stuck = 0;
  vec_t        vec[5];
  int          nxt;

  always @(negedge clk) mon_q.push_back('{tx_en_o, tx_er_o, abort_o, tx_data_o});

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i, input int mode);
    return (mode == 0) ? 8'h31 + 8'(i) : 8'(i);
  endfunction

  function automatic logic [31:0] zcrc();
    logic [31:0] c;
    c = '1;
    foreach (pay_q[i]) begin
      c = c ^ {24'd0, pay_q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic build_exp(input int len, input int mode);
    pay_q.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(pat(i, mode));
    if (PAD) while (pay_q.size() < 60) pay_q.push_back(8'h00);
    exp_fcs = zcrc();
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    foreach (pay_q[i]) exp_q.push_back(pay_q[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(exp_fcs[8*k +: 8]);
  endtask

  task automatic push(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    if (stuck) return;
    s_data_i  = d;
    s_last_i  = l;
    s_valid_i = 1'b1;
    @(negedge clk);
    while (!s_ready_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      chk("push_ready_timeout", 0, 1);
      stuck = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int len, input int mode, input int last_pos, input int stall_at);
    for (int i = 0; i < len; i++) begin
      if (i == stall_at) begin
        s_valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
      push(pat(i, mode), (i + 1 == last_pos));
    end
  endtask

  task automatic wait_idle(input int extra);
    int n;
    n = 0;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    while (busy_o && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy_o) chk("busy_timeout", 1, 0);
    repeat (extra) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string nm, input int start, input int exp_en,
                             input int exp_gap, input bit known, input logic [31:0] kfcs,
                             output int next);
    int i, s, run, bad, errs, gap;
    logic [31:0] line_fcs;
    i = start;
    while (i < mon_q.size() && !mon_q[i].en) i++;
    if (i >= mon_q.size()) begin
      chk({nm, "_present"}, 0, 1);
      next = i;
      return;
    end
    s = i;
    bad = -1;
    errs = 0;
    while (i < mon_q.size() && mon_q[i].en) begin
      if (bad < 0 && (i - s >= exp_q.size() || mon_q[i].d !== exp_q[i-s])) bad = i - s;
      if (mon_q[i].er || mon_q[i].ab) errs++;
      i++;
    end
    run = i - s;
    chk({nm, "_en_len"}, run, exp_en);
    chk({nm, "_first_bad_byte"}, bad, -1);
    chk({nm, "_err_abort"}, errs, 0);
    line_fcs = '0;
    if (run >= 4)
      line_fcs = {mon_q[s+run-1].d, mon_q[s+run-2].d, mon_q[s+run-3].d, mon_q[s+run-4].d};
    chk({nm, "_fcs"}, int'(line_fcs), int'(known ? kfcs : exp_fcs));
    gap = 0;
    while (i < mon_q.size() && !mon_q[i].en) begin
      gap++;
      i++;
    end
    if (exp_gap >= 0) chk({nm, "_ifg"}, gap, exp_gap);
    next = i;
  endtask

  task automatic check_abort(input string nm, input int exp_run, input logic [7:0] prev);
    int s, run, ers, abs, erd, erab;
    s = -1;
    ers = 0;
    abs = 0;
    erd = -1;
    erab = 0;
    foreach (mon_q[i]) begin
      if (mon_q[i].en && s < 0) s = i;
      if (mon_q[i].er) begin
        ers++;
        erd = mon_q[i].d;
        erab = mon_q[i].ab;
      end
      if (mon_q[i].ab) abs++;
    end
    run = 0;
    if (s >= 0) while (s + run < mon_q.size() && mon_q[s+run].en) run++;
    chk({nm, "_en_len"}, run, exp_run);
    chk({nm, "_er_cycles"}, ers, 1);
    chk({nm, "_abort_pulses"}, abs, 1);
    chk({nm, "_er_data"}, erd, 0);
    chk({nm, "_abort_with_er"}, erab, 1);
    if (run >= 2) begin
      chk({nm, "_marker_last"}, int'(mon_q[s+run-1].er), 1);
      chk({nm, "_byte_before"}, int'(mon_q[s+run-2].d), int'(prev));
    end else begin
      chk({nm, "_run_short"}, run, exp_run);
    end
  endtask

  initial begin
    vec[0] = '{9,   0, PAD ? 72 : 21, !PAD, 32'hCBF4_3926};
    vec[1] = '{1,   1, PAD ? 72 : 13, !PAD, 32'hD202_EF8D};
    vec[2] = '{60,  1, 72,            1'b0, 32'h0};
    vec[3] = '{59,  1, PAD ? 72 : 71, 1'b0, 32'h0};
    vec[4] = '{100, 1, 112,           1'b0, 32'h0};

    rst_i = 1'b1;
    s_data_i = 8'h00;
    s_valid_i = 1'b0;
    s_last_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_i = 1'b0;
    chk("rst_tx_en", int'(tx_en_o), 0);
    chk("rst_tx_er", int'(tx_er_o), 0);
    chk("rst_tx_data", int'(tx_data_o), 0);
    chk("rst_abort", int'(abort_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ready", int'(s_ready_o), 0);
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) begin
      mon_q.delete();
      build_exp(vec[v].len, vec[v].mode);
      send(vec[v].len, vec[v].mode, vec[v].len, -1);
      send(1, 1, 1, -1);
      wait_idle(4);
      check_frame($sformatf("vec%0d", v), 0, vec[v].exp_en, 12,
                  vec[v].known, vec[v].fcs, nxt);
    end

    mon_q.delete();
    build_exp(100, 1);
    send(100, 1, 100, -1);
    send(100, 1, 100, -1);
    wait_idle(4);
    check_frame("b2b_first", 0, 112, 12, 1'b0, 32'h0, nxt);
    check_frame("b2b_second", nxt, 112, -1, 1'b0, 32'h0, nxt);

    mon_q.delete();
    send(30, 1, 30, 20);
    wait_idle(4);
    check_abort("underflow", 8 + 20 + 1, pat(19, 1));
    mon_q.delete();
    build_exp(9, 0);
    send(9, 0, 9, -1);
    wait_idle(4);
    check_frame("after_underflow", 0, PAD ? 72 : 21, -1, !PAD, 32'hCBF4_3926, nxt);

    mon_q.delete();
    send(1600, 1, 1600, -1);
    wait_idle(4);
    check_abort("oversize", 8 + 1514 + 1, pat(1513, 1));

    send(10, 1, 30, -1);
    s_valid_i = 1'b0;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_tx_en", int'(tx_en_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_tx_er", int'(tx_er_o), 0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    mon_q.delete();
    build_exp(9, 0);
    send(9, 0, 9, -1);
    wait_idle(4);
    check_frame("after_reset", 0, PAD ? 72 : 21, -1, !PAD, 32'hCBF4_3926, nxt);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/eth_tx_framer.md
# eth_tx_framer

Byte-wide Ethernet MAC transmit framer that sequences the team's `crc32` engine. It accepts a payload stream (destination MAC through end of payload) on a valid/ready/last interface. It emits a complete frame on a registered GMII-style byte bus: preamble, SFD, payload, zero padding, 4-byte FCS, then the inter-frame gap. It sits between the packet builder and the RGMII TX serializer, and owns `crc32` (instantiated internally, `DATA_WIDTH=8`): it drives that engine's clear and enable, and reads its result.

## Interface
- `PREAMBLE_LEN`, 7: number of 0x55 bytes before the SFD.
- `IFG_LEN`, 12: idle cycles after the FCS (`tx_en_o` low).
- `MIN_PAYLOAD`, 60: minimum frame length before the FCS (used only with padding).
- `MAX_PAYLOAD`, 1514: longest accepted payload; byte counter is 11 bits.
- `clk_i` in 1: single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `s_data_i` in 8: payload byte.
- `s_valid_i` in 1: payload byte valid.
- `s_last_i` in 1: final payload byte.
- `s_ready_o` out 1: byte accepted when `s_valid_i && s_ready_o`.
- `tx_data_o` out 8: line byte (registered).
- `tx_en_o` out 1: line byte valid (registered).
- `tx_er_o` out 1: abort marker (registered).
- `busy_o` out 1: high in any state other than IDLE.
- `abort_o` out 1: one-cycle pulse when a frame is aborted.

## Operation
- States and order: IDLE → PREAMBLE → SFD → DATA → (PAD) → FCS → IFG → IDLE. Abort path: DATA → ABORT → (DRAIN) → IFG.
- IDLE: when `s_valid_i` is high, go to PREAMBLE. No byte is consumed.
- PREAMBLE: `PREAMBLE_LEN` cycles of 0x55. The `crc32` engine is held cleared (all ones) throughout.
- SFD: one cycle of 0xD5.
- DATA:
  - `s_ready_o` = 1 combinationally in this state (and in DRAIN), 0 in all others.
  - Each accepted byte is driven on `tx_data_o` at the next edge and fed to `crc32` with enable in the same cycle.
  - The byte counter increments per accepted byte.
- Leaving DATA, on `s_last_i`:
  - If count < `MIN_PAYLOAD`, go to PAD.
  - Otherwise go to FCS.
- PAD: emit 0x00 and feed each 0x00 through `crc32` until count = `MIN_PAYLOAD`, then go to FCS.
- FCS: 4 cycles. The `crc32` engine is idle, so its result C is stable. Byte k (k = 0..3) is `~bitrev8(C[31-8k -: 8])`.
- IFG: `IFG_LEN` cycles with `tx_en_o` = 0, then IDLE.
- Underflow abort: `s_valid_i` is low in a DATA cycle.
- Oversize abort: the byte counter reaches `MAX_PAYLOAD` on a byte without `s_last_i`.
- On either abort: enter ABORT for one cycle, with `tx_en_o` = 1, `tx_er_o` = 1, `tx_data_o` = 0x00, and `abort_o` pulsed. Then:
  - If `s_last_i` has already been seen, go to IFG.
  - Otherwise go to DRAIN: discard bytes until `s_valid_i && s_last_i`, then go to IFG.
- Counter arithmetic is unsigned 11-bit and never wraps, because `MAX_PAYLOAD` < 2048.

## Timing
- Reset values: state IDLE, `tx_data_o` = 0x00, `tx_en_o` = 0, `tx_er_o` = 0, `abort_o` = 0, `busy_o` = 0, counters 0, `crc32` = all ones.
- A reset in mid-frame takes effect at the next edge: outputs return to reset values and no FCS or IFG is emitted.
- Cycle T0: `s_valid_i` is high in IDLE.
- T1..T7: `tx_en_o` = 1 and `tx_data_o` = 0x55.
- T8: `tx_data_o` = 0xD5. `s_ready_o` is already high in this cycle.
- A byte accepted in cycle T appears on `tx_data_o` at T+1.
- Latency is one cycle from input to line. The FCS, PAD and DATA bytes are contiguous, with no gap.
- Frame length: `tx_en_o` is high for exactly `PREAMBLE_LEN` + 1 + max(N, `MIN_PAYLOAD`) + 4 cycles, then low for `IFG_LEN` cycles. The next T0 can occur no earlier than the last IFG cycle.
- `s_last_i` is sampled only when a byte is accepted. A one-byte payload (`s_last_i` set on the first byte) is legal.

## Configuration
- `ETH_TX_PAD_EN` defined: PAD state is present; short frames are zero-padded to `MIN_PAYLOAD` bytes before the FCS.
- `ETH_TX_PAD_EN` undefined: PAD state and `MIN_PAYLOAD` comparison are removed; DATA always goes directly to FCS on `s_last_i`.

## Test plan
- Pad off, payload ASCII "123456789" (0x31..0x39):
  - FCS bytes are 0x26, 0x39, 0xF4, 0xCB.
  - `tx_en_o` is high for 8+9+4 = 21 cycles, then low for 12 cycles.
- Pad on, 9-byte payload: bytes 9..59 on the line are 0x00, `tx_en_o` is high for 72 cycles, and the FCS equals the zlib CRC32 of the 60-byte padded payload.
- Pad on, 100-byte payload 0x00..0x63 with `s_valid_i` held high: no padding, 112 `tx_en_o` cycles, FCS matches the model, and two back-to-back frames are separated by exactly 12 idle cycles.
- Underflow: `s_valid_i` drops after byte 20. Required response:
  - One cycle with `tx_er_o` = 1 and `tx_data_o` = 0x00.
  - `abort_o` pulses.
  - DRAIN consumes the remaining bytes through `s_last_i`; no FCS is sent.
  - The next frame is correct.
- Oversize: 1600-byte payload with no `s_last_i` before byte 1514. Abort occurs after byte 1514 and bytes 1515..1600 are drained.
- Reset asserted mid-DATA: on the next cycle `tx_en_o` = 0 and `busy_o` = 0. The following frame's FCS is correct, confirming the CRC was re-cleared.
